ariane_tile_rst_seq: RTL and testbench

Reset/wake-up sequencer for a multi-core OpenPiton/Ariane tile cluster. After the global reset, it waits for the SRAM initialisation window. It then releases each core's reset one at a time, with a fixed stagger, so that L1.5/L2 init traffic does not collide. At run time it arbitrates per-core re-reset requests round-robin. For each granted request it drains the core's outstanding memory traffic, asserts that core's reset for a fixed hold time, and releases it again. It sits between the chip reset and the per-core wrapper reset inputs.

---
 rtl/ariane_tile_rst_seq.sv | 194 +++++++++++++++++++
 tb/tb_ariane_tile_rst_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ariane_tile_rst_seq.sv
// ariane_tile_rst_seq
// Reset / wake-up sequencer for a multi-core Ariane tile cluster.
// After chip reset it waits out the SRAM init window (or until the L2 says
// init is done). It then releases the per-core resets one by one with a fixed
// stagger. At run time it services per-core re-reset requests round-robin:
// drain the core's outstanding traffic (bounded by a timeout), hold the core
// in reset, then release it.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   init_done_i    early SRAM-init-complete level from the L2
//   core_rst_req_i per-core re-reset request (pulse or level, latched sticky)
//   core_idle_i    per-core "no outstanding L1.5 transactions"
//   core_rst_no    active-low reset to each core
//   busy_o         sequencer is not in RUN
//   all_up_o       every core is out of reset
//   cur_idx_o      core being released (INIT/RELEASE) or serviced (DRAIN/HOLD)
//   timeout_o      one-cycle pulse when a drain ended by timeout
module ariane_tile_rst_seq #(
  parameter int unsigned NrCores       = 4,
  parameter int unsigned InitCycles    = 32768,
  parameter int unsigned StaggerCycles = 16,
  parameter int unsigned DrainTimeout  = 1024,
  parameter int unsigned HoldCycles    = 8,
  parameter int unsigned CntWidth      = 16,
  localparam int unsigned IdxW = (NrCores > 1) ? $clog2(NrCores) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_done_i,
  input  logic [NrCores-1:0] core_rst_req_i,
  input  logic [NrCores-1:0] core_idle_i,
  output logic [NrCores-1:0] core_rst_no,
  output logic               busy_o,
  output logic               all_up_o,
  output logic [IdxW-1:0]    cur_idx_o,
  output logic               timeout_o
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam logic [CntWidth-1:0] INIT_LAST    = CntWidth'(InitCycles - 1);
  localparam logic [CntWidth-1:0] STAGGER_LAST = CntWidth'(StaggerCycles - 1);
  localparam logic [CntWidth-1:0] DRAIN_LAST   = CntWidth'(DrainTimeout - 1);
  localparam logic [CntWidth-1:0] HOLD_LAST    = CntWidth'(HoldCycles - 1);
  localparam logic [IdxW-1:0]     LAST_IDX     = IdxW'(NrCores - 1);

  // Core index + 1, wrapping at NrCores (stays 0 for a single core).
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] v);
    logic [IdxW-1:0] r;
    if (v == LAST_IDX) begin
      r = '0;
    end else begin
      r = v + IdxW'(1);
    end
    return r;
  endfunction

  state_e              state_r, state_nxt_s;
  logic [CntWidth-1:0] cnt_r, cnt_nxt_s;
  logic [NrCores-1:0]  pending_r;
  logic [NrCores-1:0]  grant_clear_s;
  logic [IdxW-1:0]     idx_r, idx_nxt_s;
  logic [IdxW-1:0]     sel_r, sel_nxt_s;
  logic [IdxW-1:0]     rr_ptr_r, rr_ptr_nxt_s;
  logic [NrCores-1:0]  core_rst_n_r, core_rst_n_nxt_s;
  logic                timeout_r, timeout_nxt_s;
  logic                grant_vld_s;
  logic [IdxW-1:0]     grant_idx_s;
  logic [IdxW-1:0]     cand_s;

  // Round-robin pick: first pending core at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      cand_s = IdxW'((32'(rr_ptr_r) + i) % NrCores);
      if (!grant_vld_s && pending_r[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
      end
    end
  end

  // Next-state, counter and per-core reset decisions.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r + CntWidth'(1);
    idx_nxt_s        = idx_r;
    sel_nxt_s        = sel_r;
    rr_ptr_nxt_s     = rr_ptr_r;
    core_rst_n_nxt_s = core_rst_n_r;
    timeout_nxt_s    = 1'b0;
    grant_clear_s    = '0;
    case (state_r)
      ST_INIT: begin
        if ((cnt_r == INIT_LAST) || init_done_i) begin
          state_nxt_s = ST_RELEASE;
          cnt_nxt_s   = '0;
          idx_nxt_s   = '0;
        end else begin
        end
      end
      ST_RELEASE: begin
        if (cnt_r == STAGGER_LAST) begin
          core_rst_n_nxt_s[idx_r] = 1'b1;
          cnt_nxt_s               = '0;
          idx_nxt_s               = next_idx(idx_r);
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_RUN;
          end else begin
          end
        end else begin
        end
      end
      ST_RUN: begin
        cnt_nxt_s = '0;
        if (grant_vld_s) begin
          sel_nxt_s                  = grant_idx_s;
          grant_clear_s[grant_idx_s] = 1'b1;
          rr_ptr_nxt_s               = next_idx(grant_idx_s);
          state_nxt_s                = ST_DRAIN;
        end else begin
        end
      end
      ST_DRAIN: begin
        // Idle has priority over the timeout on the last drain cycle.
        if (core_idle_i[sel_r]) begin
          core_rst_n_nxt_s[sel_r] = 1'b0;
          cnt_nxt_s               = '0;
          state_nxt_s             = ST_HOLD;
        end else if (cnt_r == DRAIN_LAST) begin
          core_rst_n_nxt_s[sel_r] = 1'b0;
          cnt_nxt_s               = '0;
          timeout_nxt_s           = 1'b1;
          state_nxt_s             = ST_HOLD;
        end else begin
        end
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          core_rst_n_nxt_s[sel_r] = 1'b1;
          cnt_nxt_s               = '0;
          state_nxt_s             = ST_RUN;
        end else begin
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State and output registers; a request and a grant-clear on the same
  // bit in the same cycle leave the bit set so the new request is kept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_INIT;
      cnt_r        <= '0;
      pending_r    <= '0;
      idx_r        <= '0;
      sel_r        <= '0;
      rr_ptr_r     <= '0;
      core_rst_n_r <= '0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      pending_r    <= (pending_r & ~grant_clear_s) | core_rst_req_i;
      idx_r        <= idx_nxt_s;
      sel_r        <= sel_nxt_s;
      rr_ptr_r     <= rr_ptr_nxt_s;
      core_rst_n_r <= core_rst_n_nxt_s;
      timeout_r    <= timeout_nxt_s;
    end
  end

  assign core_rst_no = core_rst_n_r;
  assign busy_o      = (state_r != ST_RUN);
  assign all_up_o    = &core_rst_n_r;
  assign cur_idx_o   = ((state_r == ST_DRAIN) || (state_r == ST_HOLD)) ? sel_r : idx_r;
  assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_ariane_tile_rst_seq.sv
// Scoreboard bench for ariane_tile_rst_seq. Stimulus tasks compute the
// expected reset-edge / timeout events from the cycle arithmetic of the
// sequencer's rules and queue them; a negedge monitor turns every observed
// core_rst_no edge and timeout pulse into an event and checks it in order.
module tb_ariane_tile_rst_seq;

  localparam int N    = 4;
  localparam int INIT = 64;
  localparam int STAG = 16;
  localparam int DT   = 32;
  localparam int HOLD = 8;

  localparam int EV_REL    = 0;
  localparam int EV_ASSERT = 1;
  localparam int EV_TO     = 2;

  typedef struct {
    int kind;
    int core;
    int cyc;
  } ev_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         init_done_i;
  logic [N-1:0] core_rst_req_i;
  logic [N-1:0] core_idle_i;
  logic [N-1:0] core_rst_no;
  logic         busy_o;
  logic         all_up_o;
  logic [1:0]   cur_idx_o;
  logic         timeout_o;

  int     cyc         = 0;
  int     vectors     = 0;
  int     miscompares = 0;
  ev_t    exp_q[$];
  bit     mon_en      = 1'b0;
  logic [N-1:0] prev_rst = '0;
  int     m_rr        = 0;

  ariane_tile_rst_seq #(
    .NrCores      (N),
    .InitCycles   (INIT),
    .StaggerCycles(STAG),
    .DrainTimeout (DT),
    .HoldCycles   (HOLD),
    .CntWidth     (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .init_done_i   (init_done_i),
    .core_rst_req_i(core_rst_req_i),
    .core_idle_i   (core_idle_i),
    .core_rst_no   (core_rst_no),
    .busy_o        (busy_o),
    .all_up_o      (all_up_o),
    .cur_idx_o     (cur_idx_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic string kname(input int k);
    if (k == EV_REL) return "release";
    if (k == EV_ASSERT) return "assert";
    return "timeout";
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int core, input int c);
    ev_t e;
    e.kind = kind;
    e.core = core;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind, input int core, input int c);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event: got %s core %0d at cycle %0d, expected no event", kname(kind), core, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.core != core || e.cyc != c) begin
        miscompares++;
        $display("FAIL event: got %s core %0d at cycle %0d, expected %s core %0d at cycle %0d",
                 kname(kind), core, c, kname(e.kind), e.core, e.cyc);
      end
    end
  endtask

  // Monitor: every core_rst_no edge and every timeout pulse is an event.
  always @(negedge clk_i) begin
    if (mon_en) begin
      for (int k = 0; k < N; k++) begin
        if (core_rst_no[k] !== prev_rst[k]) mon_event(core_rst_no[k] ? EV_REL : EV_ASSERT, k, cyc);
      end
      if (timeout_o === 1'b1) mon_event(EV_TO, int'(cur_idx_o), cyc);
    end
    prev_rst = core_rst_no;
  end

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  // Reference schedule: requests in mask are sampled at edge t with the
  // sequencer idle in RUN. Each service costs one grant cycle, a drain of
  // min(d, DT-1)+1 cycles and a hold of HOLD cycles; order is round-robin.
  task automatic model_batch(input int t, input logic [N-1:0] mask, input int d, output int rel);
    int g, c, a;
    logic [N-1:0] pend;
    g    = t + 1;
    pend = mask;
    rel  = t;
    while (pend != '0) begin
      c = -1;
      for (int k = 0; k < N; k++) begin
        if (c < 0 && pend[(m_rr + k) % N]) c = (m_rr + k) % N;
      end
      a = g + 1 + ((d < DT - 1) ? d : DT - 1);
      push(EV_ASSERT, c, a);
      if (d >= DT) push(EV_TO, c, a);
      push(EV_REL, c, a + HOLD);
      pend[c] = 1'b0;
      m_rr    = (c + 1) % N;
      rel     = a + HOLD;
      g       = rel + 1;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_core_rst_no", core_rst_no, 4'h0);
    check("rst_busy", busy_o, 1'b1);
    check("rst_all_up", all_up_o, 1'b0);
    check("rst_cur_idx", cur_idx_o, 2'd0);
    check("rst_timeout", timeout_o, 1'b0);
  endtask

  // Called at a negedge right after an edge that sampled rst_i high.
  task automatic power_on(input bit early, input logic [N-1:0] req_mask);
    int base, ex, up, rel;
    base  = cyc;
    rst_i = 1'b0;
    m_rr  = 0;
    ex    = early ? base + 10 : base + INIT;
    up    = ex + STAG * N;
    for (int k = 0; k < N; k++) push(EV_REL, k, ex + STAG * (k + 1));
    wait_until(base + 5);
    check("init_core_rst_no", core_rst_no, 4'h0);
    check("init_busy", busy_o, 1'b1);
    if (early) begin
      wait_until(base + 9);
      init_done_i = 1'b1;
      @(negedge clk_i);
      init_done_i = 1'b0;
    end
    wait_until(base + 19);
    core_rst_req_i = req_mask;
    @(negedge clk_i);
    core_rst_req_i = '0;
    wait_until(up - 1);
    check("pre_up_all_up", all_up_o, 1'b0);
    check("pre_up_busy", busy_o, 1'b1);
    wait_until(up);
    check("up_all_up", all_up_o, 1'b1);
    check("up_busy", busy_o, 1'b0);
    check("up_core_rst_no", core_rst_no, 4'hF);
    if (req_mask != '0) begin
      model_batch(up, req_mask, 0, rel);
      wait_until(rel);
      check("init_req_done", core_rst_no, 4'hF);
    end
  endtask

  // One request for core c; its idle rises d drain cycles late (d >= DT: never).
  task automatic single_req(input int c, input int d);
    int t, rel;
    core_idle_i    = 4'hF;
    core_idle_i[c] = (d == 0);
    core_rst_req_i = 4'b0001 << c;
    t = cyc + 1;
    @(negedge clk_i);
    core_rst_req_i = '0;
    model_batch(t, 4'b0001 << c, d, rel);
    wait_until(t + 1);
    check("drain_cur_idx", cur_idx_o, c);
    check("drain_busy", busy_o, 1'b1);
    if (d > 0 && d < DT) begin
      wait_until(t + 1 + d);
      core_idle_i[c] = 1'b1;
    end
    wait_until(rel - 1);
    check("hold_cur_idx", cur_idx_o, c);
    check("hold_core_low", core_rst_no[c], 1'b0);
    wait_until(rel);
    core_idle_i = 4'hF;
    check("after_hold", core_rst_no, 4'hF);
    repeat ($urandom_range(0, 3)) @(negedge clk_i);
  endtask

  task automatic batch_req(input logic [N-1:0] mask);
    int t, rel;
    core_idle_i    = 4'hF;
    core_rst_req_i = mask;
    t = cyc + 1;
    @(negedge clk_i);
    core_rst_req_i = '0;
    model_batch(t, mask, 0, rel);
    wait_until(rel);
    check("batch_done_rst", core_rst_no, 4'hF);
    check("batch_done_busy", busy_o, 1'b0);
    repeat ($urandom_range(0, 3)) @(negedge clk_i);
  endtask

  initial begin
    int t, rel, rel2, r;
    rst_i          = 1'b1;
    init_done_i    = 1'b0;
    core_rst_req_i = '0;
    core_idle_i    = 4'hF;
    repeat (3) @(negedge clk_i);
    mon_en = 1'b1;
    check_reset_outputs();

    power_on(1'b0, 4'h0);

    single_req(2, 0);
    single_req(1, 1000);
    batch_req(4'b1111);
    batch_req(4'b1001);

    // Re-request of the serviced core during its own HOLD.
    core_rst_req_i = 4'b0100;
    t = cyc + 1;
    @(negedge clk_i);
    core_rst_req_i = '0;
    model_batch(t, 4'b0100, 0, rel);
    wait_until(rel - 4);
    core_rst_req_i = 4'b0100;
    @(negedge clk_i);
    core_rst_req_i = '0;
    model_batch(rel, 4'b0100, 0, rel2);
    wait_until(rel2);
    check("rehold_done", core_rst_no, 4'hF);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        batch_req(4'($urandom_range(1, 15)));
      end else begin
        single_req(int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 40)));
      end
    end

    // Reset in the middle of HOLD; a request in the reset cycle is dropped.
    core_idle_i    = 4'hF;
    core_rst_req_i = 4'b0100;
    t = cyc + 1;
    @(negedge clk_i);
    core_rst_req_i = '0;
    push(EV_ASSERT, 2, t + 2);
    wait_until(t + 4);
    check("mid_hold_rst_no", core_rst_no, 4'b1011);
    rst_i          = 1'b1;
    core_rst_req_i = 4'b0010;
    r = cyc + 1;
    for (int k = 0; k < N; k++) begin
      if (k != 2) push(EV_ASSERT, k, r);
    end
    @(negedge clk_i);
    core_rst_req_i = '0;
    check_reset_outputs();
    @(negedge clk_i);
    power_on(1'b0, 4'b1000);

    // Reset again, then an early init_done pulse.
    rst_i = 1'b1;
    r = cyc + 1;
    for (int k = 0; k < N; k++) push(EV_ASSERT, k, r);
    @(negedge clk_i);
    check_reset_outputs();
    @(negedge clk_i);
    power_on(1'b1, 4'h0);

    repeat (20) @(negedge clk_i);
    check("events_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run by cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
